// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock blocks: countdown timer state
// encoding, default preset limits and BCD digit width.
package clock_pkg;

   // Countdown timer states
   localparam logic [1:0] ST_SET   = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_ALARM = 2'd3;

   localparam int MAX_MIN_DEF = 99;
   localparam int MAX_SEC_DEF = 59;
   localparam int BCD_W       = 4;
   localparam int CNT_W       = 7;

   // Split a 0..99 binary value into {tens, ones} BCD digits
   function automatic logic [2*BCD_W-1:0] bcd_split(input logic [CNT_W-1:0] v);
      return {BCD_W'(v / CNT_W'(10)), BCD_W'(v % CNT_W'(10))};
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge pulse generator for one raw button level. The pulse is
// registered, so it appears the cycle after the first high sample.
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   logic prev;

   // Track previous level and flag a 0->1 transition
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so prev and pulse both see the old prev.
      if (reset) begin
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         prev  <= btn;
         pulse <= btn & ~prev;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Down-counting MM:SS timer with button preset, start/pause, clear and a
// bounded alarm. Outputs four BCD digits for the display mux.
// Optional build macro TMR_AUTO_RELOAD_EN: on reaching 00:00 in RUN, pulse
// alarm for one cycle, reload from the preset and keep running.
module countdown_timer
   import clock_pkg::*;
#(
   parameter int MAX_MIN     = MAX_MIN_DEF,
   parameter int MAX_SEC     = MAX_SEC_DEF,
   parameter int ALARM_TICKS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enb,
   input  logic       mode_en,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       btn_min,
   input  logic       btn_sec,
   output logic [3:0] tm_min1,
   output logic [3:0] tm_min2,
   output logic [3:0] tm_sec1,
   output logic [3:0] tm_sec2,
   output logic       running,
   output logic       alarm
);

   localparam logic [CNT_W-1:0] MAX_MIN_C = CNT_W'(MAX_MIN);
   localparam logic [CNT_W-1:0] MAX_SEC_C = CNT_W'(MAX_SEC);
   localparam logic [CNT_W-1:0] SEC_WRAP  = CNT_W'(59);   // borrow reload while counting
   localparam int               TW        = $clog2(ALARM_TICKS + 1);
   localparam logic [TW-1:0]    TICK_LAST = TW'(ALARM_TICKS - 1);

   logic p_start, p_clear, p_min, p_sec;

   btn_edge u_start (.clk(clk), .reset(reset), .btn(btn_start), .pulse(p_start));
   btn_edge u_clear (.clk(clk), .reset(reset), .btn(btn_clear), .pulse(p_clear));
   btn_edge u_min   (.clk(clk), .reset(reset), .btn(btn_min),   .pulse(p_min));
   btn_edge u_sec   (.clk(clk), .reset(reset), .btn(btn_sec),   .pulse(p_sec));

   logic [1:0]       state, state_nx;
   logic [CNT_W-1:0] preset_min, preset_min_nx;
   logic [CNT_W-1:0] preset_sec, preset_sec_nx;
   logic [CNT_W-1:0] cnt_min, cnt_min_nx;
   logic [CNT_W-1:0] cnt_sec, cnt_sec_nx;
   logic [TW-1:0]    tick_cnt, tick_nx;
   logic             reload_flag, reload_nx;
   logic             preset_zero, cnt_one, any_pulse;

   assign preset_zero = (preset_min == '0) && (preset_sec == '0);
   assign cnt_one     = (cnt_min == '0) && (cnt_sec == CNT_W'(1));
   assign any_pulse   = p_start | p_clear | p_min | p_sec;

   // Next-state logic: clear > start > enb decrement > min/sec
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_nx      = state;
      preset_min_nx = preset_min;
      preset_sec_nx = preset_sec;
      cnt_min_nx    = cnt_min;
      cnt_sec_nx    = cnt_sec;
      tick_nx       = tick_cnt;
      reload_nx     = 1'b0;
      case (state)
         ST_SET: begin
            if (!p_clear) begin
               if (p_start && !preset_zero) begin
                  state_nx = ST_RUN;
               end else begin
                  if (p_min) preset_min_nx = (preset_min == MAX_MIN_C) ? '0 : preset_min + CNT_W'(1);
                  if (p_sec) preset_sec_nx = (preset_sec == MAX_SEC_C) ? '0 : preset_sec + CNT_W'(1);
               end
            end
            // The count mirrors the preset, so entering RUN loads it implicitly
            cnt_min_nx = preset_min_nx;
            cnt_sec_nx = preset_sec_nx;
         end
         ST_RUN: begin
            if (p_clear) begin
               state_nx   = ST_SET;
               cnt_min_nx = preset_min;
               cnt_sec_nx = preset_sec;
            end else if (p_start) begin
               state_nx = ST_PAUSE;
            end else if (enb) begin
               if (cnt_one) begin
`ifdef TMR_AUTO_RELOAD_EN
                  cnt_min_nx = preset_min;
                  cnt_sec_nx = preset_sec;
                  reload_nx  = 1'b1;
`else
                  cnt_min_nx = '0;
                  cnt_sec_nx = '0;
                  tick_nx    = '0;
                  state_nx   = ST_ALARM;
`endif
               end else if (cnt_sec == '0) begin
                  cnt_sec_nx = SEC_WRAP;
                  cnt_min_nx = cnt_min - CNT_W'(1);
               end else begin
                  cnt_sec_nx = cnt_sec - CNT_W'(1);
               end
            end
         end
         ST_PAUSE: begin
            if (p_clear) begin
               state_nx   = ST_SET;
               cnt_min_nx = preset_min;
               cnt_sec_nx = preset_sec;
            end else if (p_start) begin
               state_nx = ST_RUN;
            end
         end
         ST_ALARM: begin
            if (any_pulse || (enb && tick_cnt == TICK_LAST)) begin
               state_nx   = ST_SET;
               cnt_min_nx = preset_min;
               cnt_sec_nx = preset_sec;
            end else if (enb) begin
               tick_nx = tick_cnt + TW'(1);
            end
         end
         default: state_nx = ST_SET;
      endcase
   end

   // State, counters and registered outputs; everything freezes when mode_en is low
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_SET;
         preset_min  <= '0;
         preset_sec  <= '0;
         cnt_min     <= '0;
         cnt_sec     <= '0;
         tick_cnt    <= '0;
         reload_flag <= 1'b0;
         tm_min1     <= '0;
         tm_min2     <= '0;
         tm_sec1     <= '0;
         tm_sec2     <= '0;
         running     <= 1'b0;
         alarm       <= 1'b0;
      end else if (mode_en) begin
         state              <= state_nx;
         preset_min         <= preset_min_nx;
         preset_sec         <= preset_sec_nx;
         cnt_min            <= cnt_min_nx;
         cnt_sec            <= cnt_sec_nx;
         tick_cnt           <= tick_nx;
         reload_flag        <= reload_nx;
         {tm_min1, tm_min2} <= bcd_split(cnt_min);
         {tm_sec1, tm_sec2} <= bcd_split(cnt_sec);
         running            <= (state == ST_RUN);
         alarm              <= (state == ST_ALARM) || reload_flag;
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized scoreboard bench for countdown_timer. A seconds-based reference
// model predicts the registered outputs each cycle; a monitor compares them.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enb = 1'b0;
   logic       mode_en = 1'b1;
   logic [3:0] bv = 4'b0;         // 0 start, 1 clear, 2 min, 3 sec
   logic [3:0] tm_min1, tm_min2, tm_sec1, tm_sec2;
   logic       running, alarm;

   countdown_timer dut (
      .clk(clk), .reset(reset), .enb(enb), .mode_en(mode_en),
      .btn_start(bv[0]), .btn_clear(bv[1]), .btn_min(bv[2]), .btn_sec(bv[3]),
      .tm_min1(tm_min1), .tm_min2(tm_min2), .tm_sec1(tm_sec1), .tm_sec2(tm_sec2),
      .running(running), .alarm(alarm)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_SET, M_RUN, M_PAUSE, M_ALARM} mstate_t;
   typedef struct packed {
      logic [15:0] dig;
      logic        run;
      logic        alm;
   } exp_t;

   exp_t     exp_q[$];
   mstate_t  m_st = M_SET;
   int       m_pmin = 0, m_psec = 0;   // preset minutes / seconds
   int       m_rem = 0;                // remaining time in seconds
   int       m_ticks = 0;              // enb ticks seen in alarm
   bit       m_reload = 0;
   logic [3:0] m_prev = 0, m_pulse = 0;
   exp_t     m_out = '0;

   function automatic logic [15:0] digits_of(input int secs);
      int mm, ss;
      mm = secs / 60;
      ss = secs % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic model_step();
      logic [3:0] p;
      int preset_s;
      p = m_pulse;
      if (reset) begin
         m_st = M_SET; m_pmin = 0; m_psec = 0; m_rem = 0; m_ticks = 0;
         m_reload = 0; m_prev = 0; m_pulse = 0; m_out = '0;
         return;
      end
      if (mode_en) begin
         m_out.dig = digits_of(m_rem);
         m_out.run = (m_st == M_RUN);
         m_out.alm = (m_st == M_ALARM) || m_reload;
         m_reload  = 0;
         preset_s  = m_pmin * 60 + m_psec;
         case (m_st)
            M_SET: begin
               if (!p[1]) begin
                  if (p[0] && preset_s != 0) m_st = M_RUN;
                  else begin
                     if (p[2]) m_pmin = (m_pmin == 99) ? 0 : m_pmin + 1;
                     if (p[3]) m_psec = (m_psec == 59) ? 0 : m_psec + 1;
                  end
               end
               m_rem = m_pmin * 60 + m_psec;
            end
            M_RUN: begin
               if (p[1]) begin m_st = M_SET; m_rem = preset_s; end
               else if (p[0]) m_st = M_PAUSE;
               else if (enb) begin
                  m_rem = m_rem - 1;
                  if (m_rem == 0) begin
`ifdef TMR_AUTO_RELOAD_EN
                     m_rem = preset_s; m_reload = 1;
`else
                     m_st = M_ALARM; m_ticks = 0;
`endif
                  end
               end
            end
            M_PAUSE: begin
               if (p[1]) begin m_st = M_SET; m_rem = preset_s; end
               else if (p[0]) m_st = M_RUN;
            end
            M_ALARM: begin
               if (p != 0) begin m_st = M_SET; m_rem = preset_s; end
               else if (enb) begin
                  m_ticks++;
                  if (m_ticks == 10) begin m_st = M_SET; m_rem = preset_s; end
               end
            end
         endcase
      end
      m_pulse = bv & ~m_prev;
      m_prev  = bv;
   endtask

   // One clock: model the edge, queue the prediction, return at the falling edge
   task automatic cyc();
      @(posedge clk);
      model_step();
      exp_q.push_back(m_out);
      @(negedge clk);
   endtask

   task automatic cycles(input int n);
      repeat (n) cyc();
   endtask

   task automatic press(input int i);
      bv[i] = 1'b1; cyc();
      bv[i] = 1'b0; cyc();
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         enb = 1'b1; cyc();
         enb = 1'b0; cyc();
      end
   endtask

   task automatic dut_is(input string name, input logic [15:0] dig, input logic run, input logic alm);
      check({name, "_dig"}, {16'h0, tm_min1, tm_min2, tm_sec1, tm_sec2}, {16'h0, dig});
      check({name, "_run"}, {31'h0, running}, {31'h0, run});
      check({name, "_alm"}, {31'h0, alarm}, {31'h0, alm});
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_dig", {16'h0, tm_min1, tm_min2, tm_sec1, tm_sec2}, {16'h0, e.dig});
            check("sb_run", {31'h0, running}, {31'h0, e.run});
            check("sb_alm", {31'h0, alarm}, {31'h0, e.alm});
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      @(negedge clk);
      cycles(2);
      reset = 1'b0;
      dut_is("reset", 16'h0000, 1'b0, 1'b0);

      // Preset 03:05
      repeat (3) press(2);
      repeat (5) press(3);
      cycles(3);
      dut_is("preset", 16'h0305, 1'b0, 1'b0);

      // Start with preset 00:00 is ignored
      reset = 1'b1; cyc(); reset = 1'b0;
      press(0); cycles(3);
      dut_is("zero_start", 16'h0000, 1'b0, 1'b0);

      // 01:00 run to alarm
      press(2); press(0); cycles(3);
      dut_is("run", 16'h0100, 1'b1, 1'b0);
      tick(1); cycles(2);
      dut_is("first_tick", 16'h0059, 1'b1, 1'b0);
      tick(59); cycles(2);
      dut_is("alarm_on", 16'h0000, 1'b0, 1'b1);
      tick(9); cycles(2);
      dut_is("alarm_hold", 16'h0000, 1'b0, 1'b1);
      tick(1); cycles(2);
      dut_is("alarm_timeout", 16'h0100, 1'b0, 1'b0);

      // Alarm acknowledged by clear
      press(0); tick(60); cycles(2);
      dut_is("alarm_again", 16'h0000, 1'b0, 1'b1);
      tick(3); press(1); cycles(2);
      dut_is("alarm_ack", 16'h0100, 1'b0, 1'b0);

      // Pause beats decrement at 00:10
      reset = 1'b1; cyc(); reset = 1'b0;
      repeat (10) press(3);
      press(0); cycles(3);
      dut_is("run10", 16'h0010, 1'b1, 1'b0);
      bv[0] = 1'b1; cyc();
      bv[0] = 1'b0; enb = 1'b1; cyc();
      enb = 1'b0; cycles(3);
      dut_is("pause", 16'h0010, 1'b0, 1'b0);
      tick(5); cycles(2);
      dut_is("pause_hold", 16'h0010, 1'b0, 1'b0);
      press(0); tick(1); cycles(2);
      dut_is("resume", 16'h0009, 1'b1, 1'b0);

      // Minute wrap at 99
      reset = 1'b1; cyc(); reset = 1'b0;
      repeat (100) press(2);
      cycles(3);
      dut_is("min_wrap", 16'h0000, 1'b0, 1'b0);
      press(2); cycles(3);
      dut_is("min_after_wrap", 16'h0100, 1'b0, 1'b0);

      // Frozen while mode_en is low, no stale pulse on re-entry
      mode_en = 1'b0;
      press(2); press(3); press(0);
      mode_en = 1'b1;
      cycles(3);
      dut_is("frozen", 16'h0100, 1'b0, 1'b0);

      // Reset during RUN
      press(0); tick(2); cycles(2);
      dut_is("pre_reset", 16'h0058, 1'b1, 1'b0);
      reset = 1'b1; cyc();
      dut_is("mid_reset", 16'h0000, 1'b0, 1'b0);
      reset = 1'b0;

      // Randomized traffic, at most one button changes per cycle
      for (int i = 0; i < 3000; i++) begin
         int r;
         enb     = ($urandom_range(0, 99) < 50);
         mode_en = ($urandom_range(0, 99) < 92);
         reset   = ($urandom_range(0, 999) < 3);
         if (bv != 4'b0) begin
            if ($urandom_range(0, 99) < 60) bv = 4'b0;
         end else if ($urandom_range(0, 99) < 15) begin
            r = $urandom_range(0, 99);
            if (r < 30)      bv[0] = 1'b1;
            else if (r < 45) bv[1] = 1'b1;
            else if (r < 55) bv[2] = 1'b1;
            else             bv[3] = 1'b1;
         end
         cyc();
      end
      reset = 1'b0; enb = 1'b0; mode_en = 1'b1; bv = 4'b0;
      cycles(4);

      @(posedge clk);
      @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
